mc_control: RTL and testbench
=============================

# mc_control

Multicycle main control unit for the extended MIPS datapath. A Moore state machine decodes the instruction-register opcode/funct and sequences fetch, decode, execute, memory and writeback, one micro-step per clock. It drives all datapath enables and muxes, including the two-bit ALUOp pair consumed by the downstream ALU control block. It also implements the extended balrz instruction: R-type, funct 010110; if the Z status flag is set, jump to rs and link PC into rd.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- opcode  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- zflag  input  1  Z status flag; ALU zero for beq, stored status Z for balrz
- pcwrite, pcwritecond, iord, memread, memwrite, irwrite, alusrca, regwrite, regdst  output  1 each  standard multicycle controls
- memtoreg  output  2  writeback select: 00 ALUOut, 01 MDR, 10 PC (link)
- alusrcb  output  2  ALU B select: 00 B reg, 01 const 4, 10 signext, 11 signext<<2
- pcsource  output  2  PC select: 00 ALU, 01 ALUOut, 10 jump target, 11 rs (A reg)
- aluop1, aluop0  output  1 each  ALUOp to ALU control
- illegal  output  1  unsupported opcode seen in DECODE
- state  output  4  current state encoding, debug

## Operation
- States and encodings:
  - FETCH=0: memread, irwrite, alusrcb=01, pcwrite; pcsource=00, aluop=00, iord=0.
  - DECODE=1: alusrcb=11, aluop=00.
  - MEMADR=2: alusrca, alusrcb=10, aluop=00.
  - MEMRD=3: memread, iord.
  - MEMWB=4: regwrite, memtoreg=01, regdst=0.
  - MEMWR=5: memwrite, iord.
  - EXEC=6: alusrca, alusrcb=00, aluop=10.
  - RTWB=7: regwrite, regdst=1, memtoreg=00.
  - BEQ=8: alusrca, alusrcb=00, aluop=01, pcwritecond, pcsource=01.
  - JUMP=9: pcwrite, pcsource=10.
  - BALRZ=10: pcwrite=zflag, pcsource=11, regwrite=zflag, regdst=1, memtoreg=10.
- Every output not listed for a state is 0.
- Transitions:
  - FETCH→DECODE.
  - DECODE by opcode: 100011/101011→MEMADR; 000000 with funct 010110→BALRZ; other 000000→EXEC; 000100→BEQ; 000010→JUMP; anything else→FETCH with illegal=1 during DECODE.
  - MEMADR→MEMRD if opcode=100011, else MEMWR.
  - MEMRD→MEMWB.
  - EXEC→RTWB.
  - MEMWB, MEMWR, RTWB, BEQ, JUMP, BALRZ→FETCH.
- State codes 11–15 are unreachable. If entered, next state is FETCH and all outputs are 0.
- opcode/funct are sampled only in DECODE and MEMADR. IR is stable after FETCH because irwrite is low elsewhere.
- BALRZ with zflag=0 is a no-op: no PC or register write.
- Illegal-opcode instructions retire in 2 cycles with no architectural effect.

## Timing
- Outputs are a pure function of state, except BALRZ pcwrite/regwrite, which follow zflag combinationally within the same cycle.
- While rst_n=0: state register = FETCH asynchronously, and every output is forced 0, including state=0 and illegal=0.
- The first rising edge after rst_n deasserts performs FETCH.
- Reset mid-instruction abandons the instruction immediately. No partial write occurs after the reset assertion edge.
- Cycles per instruction, counted from the FETCH edge: lw 5, sw 4, R-type 4, beq 3, j 3, balrz 3, illegal 2.
- aluop pair per state:
  - 00 in FETCH/DECODE/MEMADR (add)
  - 10 in EXEC (funct decode)
  - 01 in BEQ (subtract)
  - 00 elsewhere

## Test plan
- Reset: hold rst_n=0 across 3 clocks → all outputs 0, state=0. Release; first edge → FETCH outputs (memread=1, irwrite=1, pcwrite=1, alusrcb=01), then state=1.
- lw (opcode 100011): state sequence 0,1,2,3,4,0. regwrite=1, memtoreg=01 only in state 4; memread=1 in states 0 and 3.
- R-type add (000000/100000) then sw (101011): add gives 0,1,6,7,0 with aluop=10 in 6 and regdst=1 in 7; sw gives 0,1,2,5,0 with memwrite=1, iord=1 in 5.
- balrz (000000/010110): with zflag=1 → state 10 shows pcwrite=1, regwrite=1, pcsource=11, memtoreg=10. Repeat with zflag=0 → pcwrite=0, regwrite=0, state returns to 0 after 3 cycles.
- beq (000100), j (000010), illegal (111111): beq has pcwritecond=1, aluop=01 in state 8. j has pcwrite=1, pcsource=10 in state 9. Illegal gives illegal=1 in state 1, then back to 0 with no write strobes.
- Reset mid-operation: drop rst_n during state 3 of lw → outputs 0 immediately. After release, sequence restarts at FETCH and state 4 never appears.

Source files
------------

// File: rtl/mc_control.sv
// Multicycle main control unit for the extended MIPS datapath.
// Moore FSM sequencing fetch/decode/execute/memory/writeback, plus the
// balrz instruction (R-type funct 010110: if Z, jump to rs and link into rd).
module mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zflag,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       alusrca,
  output logic       regwrite,
  output logic       regdst,
  output logic [1:0] memtoreg,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       aluop1,
  output logic       aluop0,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RTWB   = 4'd7;
  localparam logic [3:0] S_BEQ    = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_BALRZ  = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_BALRZ = 6'b010110;

  logic [3:0] state_q;
  logic [3:0] state_d;

  // State register; reset lands in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; IR fields only matter in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = (funct == FN_BALRZ) ? S_BALRZ : S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RTWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Datapath controls from state; held at zero while reset is asserted.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    alusrca     = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 2'b00;
    alusrcb     = 2'b00;
    pcsource    = 2'b00;
    aluop1      = 1'b0;
    aluop0      = 1'b0;
    illegal     = 1'b0;
    state       = 4'd0;
    if (rst_n) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          memread = 1'b1;
          irwrite = 1'b1;
          alusrcb = 2'b01;
          pcwrite = 1'b1;
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: illegal = 1'b0;
            default:                              illegal = 1'b1;
          endcase
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 2'b01;
        end
        S_MEMWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop1  = 1'b1;
        end
        S_RTWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_BEQ: begin
          alusrca     = 1'b1;
          aluop0      = 1'b1;
          pcwritecond = 1'b1;
          pcsource    = 2'b01;
        end
        S_JUMP: begin
          pcwrite  = 1'b1;
          pcsource = 2'b10;
        end
        S_BALRZ: begin
          // Jump and link only when Z is set; otherwise a no-op.
          pcwrite  = zflag;
          regwrite = zflag;
          pcsource = 2'b11;
          regdst   = 1'b1;
          memtoreg = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed self-checking bench for mc_control.
module tb_mc_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zflag;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       alusrca, regwrite, regdst, aluop1, aluop0, illegal;
  logic [1:0] memtoreg, alusrcb, pcsource;
  logic [3:0] state;

  int checks;
  int failures;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zflag(zflag),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .alusrca(alusrca), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .alusrcb(alusrcb), .pcsource(pcsource),
    .aluop1(aluop1), .aluop0(aluop0), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control word:
  // pcw pwc iord mr mw irw asa rw rd m2r[2] asb[2] pcs[2] op1 op0 ill
  logic [17:0] obs;
  assign obs = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                alusrca, regwrite, regdst, memtoreg, alusrcb, pcsource,
                aluop1, aluop0, illegal};

  localparam logic [17:0] E_ZERO   = 18'd0;
  localparam logic [17:0] E_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b01,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] E_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] E_DECILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,2'b00,1'b0,1'b0,1'b1};
  localparam logic [17:0] E_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] E_MEMRD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] E_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] E_MEMWR  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] E_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0};
  localparam logic [17:0] E_RTWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] E_BEQ    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b01,1'b0,1'b1,1'b0};
  localparam logic [17:0] E_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0,1'b0,1'b0};
  localparam logic [17:0] E_BALRZ1 = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b10,2'b00,2'b11,1'b0,1'b0,1'b0};
  localparam logic [17:0] E_BALRZ0 = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b11,1'b0,1'b0,1'b0};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    opcode = 6'b000010;
    funct  = 6'd0;
    zflag  = 1'b0;
    #1;
    checks++;
    if (obs !== E_ZERO || state !== 4'd0) begin
      failures++;
      $display("FAIL reset_immediate: outs=%h state=%0d required outs=%h state=0", obs, state, E_ZERO);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== E_ZERO || state !== 4'd0) begin
      failures++;
      $display("FAIL reset_held: outs=%h state=%0d required outs=%h state=0", obs, state, E_ZERO);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== E_FETCH || state !== 4'd0) begin
      failures++;
      $display("FAIL reset_release_fetch: outs=%h state=%0d required outs=%h state=0", obs, state, E_FETCH);
    end
    tick();
    checks++;
    if (obs !== E_DECODE || state !== 4'd1) begin
      failures++;
      $display("FAIL reset_first_decode: outs=%h state=%0d required outs=%h state=1", obs, state, E_DECODE);
    end
    tick();
    tick();
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL reset_j_retire: state=%0d required 0", state);
    end
  endtask

  task automatic test_lw();
    logic [3:0]  es [5];
    logic [17:0] eo [5];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    eo = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
    opcode = 6'b100011;
    funct  = 6'd0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== es[i] || obs !== eo[i]) begin
        failures++;
        $display("FAIL lw_step%0d: state=%0d outs=%h required state=%0d outs=%h", i, state, obs, es[i], eo[i]);
      end
      tick();
    end
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL lw_retire: state=%0d required 0", state);
    end
  endtask

  task automatic test_rtype_sw();
    logic [3:0]  es [8];
    logic [17:0] eo [8];
    es = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd2, 4'd5};
    eo = '{E_FETCH, E_DECODE, E_EXEC, E_RTWB, E_FETCH, E_DECODE, E_MEMADR, E_MEMWR};
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin opcode = 6'b000000; funct = 6'b100000; end
      if (i == 4) begin opcode = 6'b101011; funct = 6'b000000; end
      checks++;
      if (state !== es[i] || obs !== eo[i]) begin
        failures++;
        $display("FAIL add_sw_step%0d: state=%0d outs=%h required state=%0d outs=%h", i, state, obs, es[i], eo[i]);
      end
      tick();
    end
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL sw_retire: state=%0d required 0", state);
    end
  endtask

  task automatic test_balrz();
    logic [3:0]  es [6];
    logic [17:0] eo [6];
    es = '{4'd0, 4'd1, 4'd10, 4'd0, 4'd1, 4'd10};
    eo = '{E_FETCH, E_DECODE, E_BALRZ1, E_FETCH, E_DECODE, E_BALRZ0};
    opcode = 6'b000000;
    funct  = 6'b010110;
    for (int i = 0; i < 6; i++) begin
      zflag = (i < 3);
      #1;
      checks++;
      if (state !== es[i] || obs !== eo[i]) begin
        failures++;
        $display("FAIL balrz_step%0d: state=%0d outs=%h required state=%0d outs=%h", i, state, obs, es[i], eo[i]);
      end
      if (i == 5) begin
        // Z rising inside BALRZ must raise the strobes in the same cycle.
        zflag = 1'b1;
        #1;
        checks++;
        if (obs !== E_BALRZ1) begin
          failures++;
          $display("FAIL balrz_zflag_comb: outs=%h required %h", obs, E_BALRZ1);
        end
        zflag = 1'b0;
        #1;
      end
      tick();
    end
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL balrz_retire: state=%0d required 0", state);
    end
  endtask

  task automatic test_beq_j_illegal();
    logic [3:0]  es [8];
    logic [17:0] eo [8];
    es = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9, 4'd0, 4'd1};
    eo = '{E_FETCH, E_DECODE, E_BEQ, E_FETCH, E_DECODE, E_JUMP, E_FETCH, E_DECILL};
    funct = 6'd0;
    zflag = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) opcode = 6'b000100;
      if (i == 3) opcode = 6'b000010;
      if (i == 6) opcode = 6'b111111;
      #1;
      checks++;
      if (state !== es[i] || obs !== eo[i]) begin
        failures++;
        $display("FAIL branch_step%0d: state=%0d outs=%h required state=%0d outs=%h", i, state, obs, es[i], eo[i]);
      end
      tick();
    end
    checks++;
    if (state !== 4'd0 || obs !== E_FETCH) begin
      failures++;
      $display("FAIL illegal_retire: state=%0d outs=%h required state=0 outs=%h", state, obs, E_FETCH);
    end
    zflag = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic saw4;
    opcode = 6'b100011;
    funct  = 6'd0;
    tick();
    tick();
    tick();
    checks++;
    if (state !== 4'd3) begin
      failures++;
      $display("FAIL mid_reach_memrd: state=%0d required 3", state);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== E_ZERO || state !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset_outs: outs=%h state=%0d required outs=%h state=0", obs, state, E_ZERO);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || obs !== E_FETCH) begin
      failures++;
      $display("FAIL mid_restart_fetch: state=%0d outs=%h required state=0 outs=%h", state, obs, E_FETCH);
    end
    opcode = 6'b000100;
    saw4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (state == 4'd4) saw4 = 1'b1;
    end
    checks++;
    if (saw4 !== 1'b0) begin
      failures++;
      $display("FAIL mid_no_memwb: saw state 4 after reset, required never");
    end
    checks++;
    if (state !== 4'd1) begin
      failures++;
      $display("FAIL mid_beq_next_decode: state=%0d required 1", state);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_lw();
    test_rtype_sw();
    test_balrz();
    test_beq_j_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
